// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the ex_muldiv RV32M/RV64M execute unit:
// funct7/funct3 codes, FSM state encodings and write/hold strobe levels.
package ex_muldiv_pkg;

    localparam logic [6:0] INST_MULDIV = 7'b0000001;

    localparam logic [2:0] INST_MUL    = 3'b000;
    localparam logic [2:0] INST_MULH   = 3'b001;
    localparam logic [2:0] INST_MULHSU = 3'b010;
    localparam logic [2:0] INST_MULHU  = 3'b011;
    localparam logic [2:0] INST_DIV    = 3'b100;
    localparam logic [2:0] INST_DIVU   = 3'b101;
    localparam logic [2:0] INST_REM    = 3'b110;
    localparam logic [2:0] INST_REMU   = 3'b111;

    localparam logic WriteEnable = 1'b1;
    localparam logic HoldEnable  = 1'b1;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    // funct3 bit 2 separates the divide group from the multiply group
    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// Iterative unsigned datapath for ex_muldiv: shift-add multiply into a
// 2*XLEN accumulator, or restoring radix-2 divide (quotient in lo, remainder
// in hi). One step per cycle; 'last' flags the final step.
module ex_muldiv_iter
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    output logic            last,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = $clog2(XLEN);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN:0]     sum;
    logic [XLEN:0]     trial;
    logic [XLEN:0]     diff;
    logic              unused_rem_msb;

    assign last           = step && (cnt_q == CW'(XLEN - 1));
    assign hi             = is_div ? rem_q[XLEN-1:0] : acc_q[2*XLEN-1:XLEN];
    assign lo             = acc_q[XLEN-1:0];
    // after each restore the remainder is below the divisor, so its top bit is always 0
    assign unused_rem_msb = rem_q[XLEN];

    // one multiply or divide step per cycle, or a fresh load of the operands
    always_comb begin
        acc_d = acc_q;
        rem_d = rem_q;
        cnt_d = cnt_q;
        sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_mag} : '0);
        trial = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
        diff  = trial - {1'b0, b_mag};
        if (load) begin
            acc_d = {{XLEN{1'b0}}, a_mag};
            rem_d = '0;
            cnt_d = '0;
        end else if (step) begin
            cnt_d = last ? '0 : cnt_q + CW'(1);
            if (is_div) begin
                acc_d[XLEN-1:0] = {acc_q[XLEN-2:0], ~diff[XLEN]};
                rem_d           = diff[XLEN] ? trial : diff;
            end else begin
                acc_d = {sum, acc_q[XLEN-1:1]};
            end
        end
    end

    // datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            rem_q <= rem_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle RV32M/RV64M execute unit (FSM, signs, special cases,
// flush, write-back). Define MULDIV_FAST_MUL_EN for a single-cycle multiplier.
//
//   state   | meaning
//   MD_IDLE | waiting for a request
//   MD_CALC | XLEN iterative mul/div steps
//   MD_FIX  | select result half, apply sign and special cases
//   MD_DONE | one-cycle write-back; may accept the next request
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            hold_flag_o,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            rd_wen_o
);

    md_state_e         state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              s1_q, s1_d, s2_q, s2_d;
`ifdef MULDIV_FAST_MUL_EN
    logic [XLEN-1:0]   a_q, a_d;
`endif

    logic              accept, sgn1, sgn2, s1, s2, last;
    logic [XLEN-1:0]   mag1, mag2, raw_hi, raw_lo, quo, rem, res_fix;
    logic [2*XLEN-1:0] prod, prod_fix;

    assign accept = start_i && !flush_i && (state_q == MD_IDLE || state_q == MD_DONE);

    // operand signedness and magnitudes for the incoming request
    always_comb begin
        sgn1 = (op_i == INST_MULH) || (op_i == INST_MULHSU) || (op_i == INST_DIV) || (op_i == INST_REM);
        sgn2 = (op_i == INST_MULH) || (op_i == INST_DIV) || (op_i == INST_REM);
        s1   = sgn1 && op1_i[XLEN-1];
        s2   = sgn2 && op2_i[XLEN-1];
        mag1 = s1 ? -op1_i : op1_i;
        mag2 = s2 ? -op2_i : op2_i;
    end

    ex_muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .step   (state_q == MD_CALC),
        .is_div (op_is_div(op_q)),
        .a_mag  (mag1),
        .b_mag  (b_q),
        .last   (last),
        .hi     (raw_hi),
        .lo     (raw_lo)
    );

    // result selection and sign fix-up; a zero divisor forces an all-ones quotient
    always_comb begin
`ifdef MULDIV_FAST_MUL_EN
        prod = {{XLEN{1'b0}}, a_q} * {{XLEN{1'b0}}, b_q};
`else
        prod = {raw_hi, raw_lo};
`endif
        prod_fix = (s1_q ^ s2_q) ? -prod : prod;
        quo      = (s1_q ^ s2_q) ? -raw_lo : raw_lo;
        if (b_q == '0) quo = '1;
        rem      = s1_q ? -raw_hi : raw_hi;
        case (op_q)
            INST_MUL:             res_fix = prod_fix[XLEN-1:0];
            INST_DIV, INST_DIVU:  res_fix = quo;
            INST_REM, INST_REMU:  res_fix = rem;
            default:              res_fix = prod_fix[2*XLEN-1:XLEN];
        endcase
    end

    // next-state and register updates; flush overrides everything
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        b_d     = b_q;
        res_d   = res_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
`ifdef MULDIV_FAST_MUL_EN
        a_d     = a_q;
`endif
        case (state_q)
            MD_IDLE, MD_DONE: begin
                if (accept) begin
                    op_d = op_i;
                    rd_d = rd_addr_i;
                    b_d  = mag2;
                    s1_d = s1;
                    s2_d = s2;
`ifdef MULDIV_FAST_MUL_EN
                    a_d     = mag1;
                    state_d = op_is_div(op_i) ? MD_CALC : MD_FIX;
`else
                    state_d = MD_CALC;
`endif
                end else begin
                    state_d = MD_IDLE;
                end
            end
            MD_CALC: if (last) state_d = MD_FIX;
            MD_FIX: begin
                res_d   = res_fix;
                state_d = MD_DONE;
            end
            default: state_d = MD_IDLE;
        endcase
        if (flush_i) state_d = MD_IDLE;
    end

    // FSM and control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            b_q     <= '0;
            res_q   <= '0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
            a_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            b_q     <= b_d;
            res_q   <= res_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
`ifdef MULDIV_FAST_MUL_EN
            a_q     <= a_d;
`endif
        end
    end

    assign hold_flag_o = (accept || (!flush_i && (state_q == MD_CALC || state_q == MD_FIX))) ? HoldEnable : 1'b0;
    assign rd_wen_o    = (state_q == MD_DONE && !flush_i) ? WriteEnable : 1'b0;
    assign rd_addr_o   = (state_q == MD_DONE) ? rd_q : '0;
    assign rd_data_o   = (state_q == MD_DONE) ? res_q : '0;

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Parametrised multi-cycle RV32M/RV64M execute unit beside the integer execute stage, which dispatches it on opcode `INST_TYPE_R_M` with funct7 `0000001`. It runs MUL/MULH/MULHSU/MULHU and DIV/DIVU/REM/REMU iteratively. While it works it asserts `hold_flag_o` to ctrl, and when finished it returns one register write-back pulse. It is the first execute resource with internal state, abort-on-flush and a result handshake.

## Interface
- XLEN, 32: operand and result width; even, ≥ 8.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  request; operands valid this cycle.
- op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op1_i  in  XLEN  rs1 value.
- op2_i  in  XLEN  rs2 value.
- rd_addr_i  in  5  destination register.
- flush_i  in  1  ctrl jump/flush; aborts the operation in flight.
- hold_flag_o  out  1  stall request to ctrl.
- rd_addr_o  out  5  write-back address.
- rd_data_o  out  XLEN  write-back data.
- rd_wen_o  out  1  write-back strobe, one-cycle pulse.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **Reset:** state IDLE, counter 0, all registers 0. Outputs are all zero: `hold_flag_o`, `rd_wen_o`, `rd_addr_o`, `rd_data_o`.
- **Accept:** the unit accepts when it is in IDLE or DONE with `start_i`=1 and `flush_i`=0. It latches the op, the operands and `rd_addr_i`.
  - Signed ops store operand magnitudes and record the result sign.
  - `start_i` in CALC or FIX is ignored.
- **CALC:** XLEN iterations, one per cycle, counter 0..XLEN-1.
  - Multiply: shift-add into a 2·XLEN accumulator.
  - Divide: restoring radix-2 divide, producing one quotient bit per cycle. The remainder register is XLEN+1 bits wide.
- **FIX:** select the result and negate it by the recorded sign.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - Signed quotient sign = sign(op1) XOR sign(op2). Signed remainder takes the sign of op1.
- **DONE:** `rd_wen_o`=1, with `rd_addr_o` and `rd_data_o` driven from registers.
  - The next state is CALC if a new request is accepted, otherwise IDLE.
  - Outside DONE, `rd_wen_o`=0 and `rd_addr_o`/`rd_data_o` are 0.
- **Divide by zero:**
  - DIV/DIVU: quotient = all ones.
  - REM/REMU: remainder = op1.
  - No trap. The unit still takes full latency.
- **Signed overflow** (op1 = −2^(XLEN−1), op2 = −1):
  - DIV returns op1.
  - REM returns 0.
- **rd_addr_i = 0:** the operation runs normally and `rd_wen_o` pulses. The register file discards the write.
- **Flush:** `flush_i`=1 in any state returns the unit to IDLE next cycle.
  - No write-back occurs, and `hold_flag_o` is 0 in that cycle.
  - Flush in the same cycle as `start_i` rejects the start.

## Timing
- **Accept cycle T:**
  - CALC occupies T+1..T+XLEN, FIX is T+XLEN+1, DONE is T+XLEN+2.
  - Latency is XLEN+2 cycles.
- **hold_flag_o:** `start_i`&&!`flush_i` in IDLE/DONE, OR state ∈ {CALC, FIX}.
  - This is combinational from `start_i`, so the stall starts in cycle T.
  - It is low in the DONE cycle, which lets the pipeline advance with the result.
- **Back-to-back:** a request presented in DONE starts CALC at DONE+1, with no idle bubble.
- **Async reset mid-operation:** immediate return to the reset values; the result is lost.

## Configuration
- **`MULDIV_FAST_MUL_EN` defined:**
  - MUL* ops skip CALC. An XLEN×XLEN single-cycle product is registered in FIX.
  - Multiply latency is 2 (FIX at T+1, DONE at T+2).
  - Divide latency is unchanged.
- **Undefined:** multiply uses the iterative XLEN-cycle path, so the multiplier array is not synthesised.

## Structure
- **Shared defines header:**
  - funct7 `INST_MULDIV` (0000001).
  - Eight op codes (`INST_MUL` … `INST_REMU`).
  - State encodings `MD_IDLE`/`MD_CALC`/`MD_FIX`/`MD_DONE`.
  - Reuses the existing `WriteEnable`/`HoldEnable` constants.
- **Sub-module `muldiv_iter`:** the iterative datapath, holding accumulator, remainder, counter and step logic.
  - Ports: `load`, `step`, `is_div`, magnitudes in; `last` and raw hi/lo out.
- **Top level:** holds the FSM, sign handling, special cases, flush and the outputs.

## Test plan
- **XLEN=32, MUL** 0x0000_0007 × 0xFFFF_FFFD → rd_data 0xFFFF_FFEB; `rd_wen_o` pulses exactly at T+34 (T+2 with `MULDIV_FAST_MUL_EN`); hold is high T..T+33.
- **MULH** 0x8000_0000 × 0x8000_0000 → 0x4000_0000. **MULHU** same operands → 0x4000_0000. **MULHSU** 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFF.
- **DIV** −7 / 2 → 0xFFFF_FFFD. **REM** −7 / 2 → 0xFFFF_FFFF. **DIVU** 0xFFFF_FFFF / 2 → 0x7FFF_FFFF.
- **DIV** x/0 → 0xFFFF_FFFF. **REMU** 0x1234/0 → 0x1234. **DIV** 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000. **REM** with the same operands → 0.
- **Flush at T+10:**
  - No `rd_wen_o`, and hold drops at T+10.
  - A new start at T+12 completes at T+46.
- **Back-to-back:** a second request held high in the DONE cycle yields a second write at T+68 with correct data.
- **rst_n low at T+5:** all outputs are 0 immediately; no write-back follows.
